led_mode_ctrl: RTL and testbench

Mode controller for the two-LED indicator output. It sequences the LEDs through four display modes: off, alternating blink, synchronous blink and PWM breathing. Modes are selected either by a step pulse (debounced key) or by a direct load from system logic. It sits between the key/debounce logic or control registers and the `led[1:0]` board pins, and provides a common millisecond timebase for all modes.

---
 rtl/led_pkg.sv | 18 +
 rtl/tick_gen.sv | 26 ++
 rtl/led_mode_ctrl.sv | 155 +++++++++++++++
 tb/tb_led_mode_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the LED indicator mode controller.
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF    = 2'd0,
        LED_ALT    = 2'd1,
        LED_SYNC   = 2'd2,
        LED_BREATH = 2'd3
    } led_mode_e;

    localparam int PWM_W = 4;
    localparam logic [PWM_W-1:0] DUTY_MAX = 4'd15;

    function automatic led_mode_e mode_inc(input led_mode_e m);
        return led_mode_e'(m + 2'd1);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks.
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/led_mode_ctrl.sv
// Two-LED indicator mode controller: off, alternating/sync blink,
// PWM breathing; modes stepped by pulse or loaded directly.
module led_mode_ctrl
    import led_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TICK_HZ     = 1000,
    parameter int BLINK_TICKS = 500,
    parameter int RAMP_TICKS  = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_next,
    input  logic       mode_ld,
    input  logic [1:0] mode_sel,
    output logic [1:0] mode,
    output logic [1:0] led
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int BW  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int RW  = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
    localparam logic [RW-1:0] RAMP_LAST  = RW'(RAMP_TICKS - 1);

    led_mode_e        r_mode;
    led_mode_e        w_mode_nxt;
    logic             w_chg;
    logic             w_tick;
    logic             w_blink_en;
    logic             w_breath;
    logic [BW-1:0]    r_blink;
    logic             r_ph;
    logic [PWM_W-1:0] r_pwm;
    logic [PWM_W-1:0] r_duty;
    logic             r_dir_up;
    logic [RW-1:0]    r_ramp;
    logic [1:0]       w_led;
    logic [1:0]       r_led;

    tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    // Load takes precedence over step when both pulse together.
    always_comb begin
        w_mode_nxt = r_mode;
        w_chg      = 1'b0;
        if (mode_ld) begin
            w_mode_nxt = led_mode_e'(mode_sel);
            w_chg      = 1'b1;
        end else if (mode_next) begin
            w_mode_nxt = mode_inc(r_mode);
            w_chg      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= LED_ALT;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    assign w_blink_en = (r_mode == LED_ALT) || (r_mode == LED_SYNC);
    assign w_breath   = (r_mode == LED_BREATH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink <= '0;
            r_ph    <= 1'b0;
        end else if (w_chg || !w_blink_en) begin
            r_blink <= '0;
            r_ph    <= 1'b0;
        end else if (w_tick) begin
            if (r_blink == BLINK_LAST) begin
                r_blink <= '0;
                r_ph    <= ~r_ph;
            end else begin
                r_blink <= r_blink + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= '0;
        end else if (w_chg || !w_breath) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= r_pwm + 1'b1;
        end
    end

    // Triangle ramp: direction reverses on the step after an endpoint.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ramp   <= '0;
            r_duty   <= '0;
            r_dir_up <= 1'b1;
        end else if (w_chg || !w_breath) begin
            r_ramp   <= '0;
            r_duty   <= '0;
            r_dir_up <= 1'b1;
        end else if (w_tick) begin
            if (r_ramp == RAMP_LAST) begin
                r_ramp <= '0;
                if (r_dir_up) begin
                    if (r_duty == DUTY_MAX) begin
                        r_dir_up <= 1'b0;
                        r_duty   <= DUTY_MAX - 1'b1;
                    end else begin
                        r_duty <= r_duty + 1'b1;
                    end
                end else begin
                    if (r_duty == '0) begin
                        r_dir_up <= 1'b1;
                        r_duty   <= 4'd1;
                    end else begin
                        r_duty <= r_duty - 1'b1;
                    end
                end
            end else begin
                r_ramp <= r_ramp + 1'b1;
            end
        end
    end

    always_comb begin
        w_led = 2'b00;
        unique case (r_mode)
            LED_OFF:    w_led = 2'b00;
            LED_ALT:    w_led = {r_ph, ~r_ph};
            LED_SYNC:   w_led = {r_ph, r_ph};
            LED_BREATH: w_led = {2{r_pwm < r_duty}};
            default:    w_led = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= 2'b01;
        end else begin
            r_led <= w_led;
        end
    end

    assign mode = r_mode;
    assign led  = r_led;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Bench for led_mode_ctrl: directed scenarios plus random pulses
// checked against a time-based reference model.
module tb_led_mode_ctrl;

    localparam int DIVM = 10;
    localparam int BL   = 3;
    localparam int RP   = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode_next = 1'b0;
    logic       mode_ld = 1'b0;
    logic [1:0] mode_sel = 2'd0;
    logic [1:0] mode;
    logic [1:0] led;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: edges since reset, edge of last mode change, mode
    int         m_k;
    int         m_m;
    int         m_mode;
    logic [1:0] e_mode;
    logic [1:0] e_led;

    led_mode_ctrl #(
        .CLK_HZ      (100),
        .TICK_HZ     (10),
        .BLINK_TICKS (BL),
        .RAMP_TICKS  (RP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode_next (mode_next),
        .mode_ld   (mode_ld),
        .mode_sel  (mode_sel),
        .mode      (mode),
        .led       (led)
    );

    always #5 clk = ~clk;

    function automatic int ticks_since(int m, int k);
        return k / DIVM - m / DIVM;
    endfunction

    function automatic int duty_of(int m, int k);
        int s;
        s = (ticks_since(m, k) / RP) % 30;
        return (s <= 15) ? s : 30 - s;
    endfunction

    function automatic logic [1:0] led_of(int md, int m, int k);
        logic ph;
        logic on;
        ph = ((ticks_since(m, k) / BL) % 2) == 1;
        on = ((k - m) % 16) < duty_of(m, k);
        case (md)
            0:       return 2'b00;
            1:       return {ph, ~ph};
            2:       return {ph, ph};
            default: return {on, on};
        endcase
    endfunction

    function automatic void model_reset();
        m_k    = 0;
        m_m    = 0;
        m_mode = 1;
        e_mode = 2'd1;
        e_led  = 2'b01;
    endfunction

    function automatic void model_step(logic nx, logic ld, logic [1:0] sel);
        e_led = led_of(m_mode, m_m, m_k);
        m_k++;
        if (ld) begin
            m_mode = int'(sel);
            m_m    = m_k;
        end else if (nx) begin
            m_mode = (m_mode + 1) % 4;
            m_m    = m_k;
        end
        e_mode = 2'(m_mode);
    endfunction

    task automatic drive(input logic nx, input logic ld, input logic [1:0] sel);
        @(negedge clk);
        mode_next = nx;
        mode_ld   = ld;
        mode_sel  = sel;
        @(posedge clk);
        model_step(nx, ld, sel);
        #1;
        mode_next = 1'b0;
        mode_ld   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        n_vec++;
        if (mode !== 2'd1 || led !== 2'b01) begin
            n_err++;
            $display("FAIL reset_hold mode=%0d want 1 led=%b want 01", mode, led);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 70; i++) begin
            drive(1'b0, 1'b0, 2'd0);
            n_vec++;
            if (mode !== e_mode || led !== e_led) begin
                n_err++;
                $display("FAIL reset_run cyc=%0d mode=%0d/%0d led=%b/%b",
                         i, mode, e_mode, led, e_led);
            end
            if (i == 30) begin
                n_vec++;
                if (led !== 2'b10) begin
                    n_err++;
                    $display("FAIL first_toggle led=%b want 10", led);
                end
            end
        end
    endtask

    task automatic test_mode_step();
        logic [1:0] seq [4];
        seq[0] = 2'd2; seq[1] = 2'd3; seq[2] = 2'd0; seq[3] = 2'd1;
        drive(1'b0, 1'b1, 2'd1);
        for (int p = 0; p < 4; p++) begin
            drive(1'b1, 1'b0, 2'd0);
            n_vec++;
            if (mode !== seq[p]) begin
                n_err++;
                $display("FAIL step_seq p=%0d mode=%0d want %0d", p, mode, seq[p]);
            end
            for (int i = 0; i < 4; i++) begin
                drive(1'b0, 1'b0, 2'd0);
                n_vec++;
                if (mode !== e_mode || led !== e_led) begin
                    n_err++;
                    $display("FAIL step_run p=%0d mode=%0d/%0d led=%b/%b",
                             p, mode, e_mode, led, e_led);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        drive(1'b0, 1'b1, 2'd1);
        drive(1'b0, 1'b0, 2'd0);
        drive(1'b1, 1'b1, 2'd0);
        n_vec++;
        if (mode !== 2'd0) begin
            n_err++;
            $display("FAIL simul_mode mode=%0d want 0", mode);
        end
        drive(1'b0, 1'b0, 2'd0);
        n_vec++;
        if (led !== 2'b00 || led !== e_led) begin
            n_err++;
            $display("FAIL simul_led led=%b want 00", led);
        end
    endtask

    task automatic test_sync();
        drive(1'b0, 1'b1, 2'd2);
        for (int i = 0; i < 75; i++) begin
            drive(1'b0, 1'b0, 2'd0);
            n_vec++;
            if (mode !== e_mode || led !== e_led) begin
                n_err++;
                $display("FAIL sync cyc=%0d mode=%0d/%0d led=%b/%b",
                         i, mode, e_mode, led, e_led);
            end
        end
    endtask

    task automatic test_breath();
        drive(1'b0, 1'b1, 2'd3);
        for (int i = 0; i < 400; i++) begin
            drive(1'b0, 1'b0, 2'd0);
            n_vec++;
            if (mode !== e_mode || led !== e_led) begin
                n_err++;
                $display("FAIL breath cyc=%0d duty=%0d led=%b/%b",
                         i, duty_of(m_m, m_k), led, e_led);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 2'd0);
            n_vec++;
            if (mode !== e_mode || led !== e_led) begin
                n_err++;
                $display("FAIL b2b cyc=%0d mode=%0d/%0d led=%b/%b",
                         i, mode, e_mode, led, e_led);
            end
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 39));
            drive(r == 0 || r == 2, r == 1 || r == 2, 2'($urandom_range(0, 3)));
            n_vec++;
            if (mode !== e_mode || led !== e_led) begin
                n_err++;
                $display("FAIL random cyc=%0d mode=%0d/%0d led=%b/%b",
                         i, mode, e_mode, led, e_led);
            end
        end
    endtask

    task automatic test_mid_reset();
        int guard;
        drive(1'b0, 1'b1, 2'd3);
        guard = 0;
        while (duty_of(m_m, m_k) != 7 && guard < 200) begin
            drive(1'b0, 1'b0, 2'd0);
            guard++;
        end
        n_vec++;
        if (guard >= 200 || mode !== 2'd3) begin
            n_err++;
            $display("FAIL midrst_setup mode=%0d want 3 guard=%0d", mode, guard);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (mode !== 2'd1 || led !== 2'b01) begin
            n_err++;
            $display("FAIL midrst_async mode=%0d want 1 led=%b want 01", mode, led);
        end
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
        drive(1'b0, 1'b1, 2'd3);
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 1'b0, 2'd0);
            n_vec++;
            if (mode !== e_mode || led !== e_led) begin
                n_err++;
                $display("FAIL midrst_run cyc=%0d mode=%0d/%0d led=%b/%b",
                         i, mode, e_mode, led, e_led);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_mode_step();
        test_simultaneous();
        test_sync();
        test_breath();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
